// File: rtl/avr_io_pkg.sv
// Shared types for the IO-bus initiator: bus widths, FSM states, queued command layout.
package avr_io_pkg;

    localparam int IO_ADDR_W = 6;
    localparam int IO_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACCESS,
        RESP
    } io_state_e;

    typedef struct packed {
        logic                 write;
        logic [IO_ADDR_W-1:0] addr;
        logic [IO_DATA_W-1:0] wdata;
    } io_cmd_t;

    localparam int IO_CMD_W = $bits(io_cmd_t);

endpackage

// File: rtl/avr_io_cmd_fifo.sv
// Command queue: DEPTH-entry circular buffer, push refused when full, pop refused when empty.
module avr_io_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rptr_q];

    // full is checked on the registered count, so a pop never frees a slot in the same cycle
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/avr_io_master.sv
// Second master on the 6-bit IO bus: queues commands, arbitrates, strobes peripherals, returns read data.
module avr_io_master
    import avr_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = IO_ADDR_W,
    parameter int DATA_WIDTH = IO_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic [ADDR_WIDTH-1:0] io_addr,
    inout  wire  [DATA_WIDTH-1:0] io_data,
    output logic                  io_read,
    output logic                  io_write,
    output logic                  busy
);
    io_state_e             state_q, state_d;
    io_cmd_t               cmd_in, head;
    logic                  fifo_full, fifo_empty, pop, in_access;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    assign cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    avr_io_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IO_CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (cmd_valid),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Strobes are purely combinational from state so an async reset releases the bus at once
    assign in_access = (state_q == ACCESS);
    assign pop       = in_access && bus_gnt;
    assign cmd_ready = !fifo_full;
    assign bus_req   = (state_q == REQ) || in_access;
    assign io_write  = in_access && head.write && bus_gnt;
    assign io_read   = in_access && !head.write && bus_gnt;
    assign io_addr   = in_access ? head.addr : '0;
    assign io_data   = io_write ? head.wdata : {DATA_WIDTH{1'bz}};
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE:   if (!fifo_empty) state_d = REQ;
            REQ:    if (bus_gnt) state_d = ACCESS;
            // A revoked grant leaves the head in place and re-arbitrates for the same command
            ACCESS: begin
                if (!bus_gnt) begin
                    state_d = REQ;
                end else if (head.write) begin
                    state_d = IDLE;
                end else begin
                    state_d     = RESP;
                    rsp_rdata_d = io_data;
                end
            end
            RESP:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
